// File: rtl/window_scheduler_if.sv
// Window handshake bundle: the scheduler presents one window position at a time,
// and the consumer accepts it with win_ready.
interface window_scheduler_if #(
  parameter int COORD_W = 16
);
  logic               win_valid;
  logic               win_ready;
  logic [3:0]         win_level;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic               win_last_in_level;
  logic               win_last;

  modport master (
    output win_valid, win_level, win_row, win_col, win_last_in_level, win_last,
    input  win_ready
  );

  modport slave (
    input  win_valid, win_level, win_row, win_col, win_last_in_level, win_last,
    output win_ready
  );
endinterface

// File: rtl/window_scheduler.sv
// Raster scan of sliding-window top-left positions over a range of pyramid levels,
// advancing one position per accepted handshake and skipping empty levels.
module window_scheduler #(
  parameter int NUM_LEVELS  = 9,
  parameter int WINDOW_SIZE = 24,
  parameter int COORD_W     = 16,
  parameter logic [NUM_LEVELS-1:0][COORD_W-1:0] LEVEL_WIDTHS = {
    16'd40, 16'd48, 16'd64, 16'd80, 16'd96, 16'd128, 16'd160, 16'd240, 16'd320},
  parameter logic [NUM_LEVELS-1:0][COORD_W-1:0] LEVEL_HEIGHTS = {
    16'd30, 16'd36, 16'd48, 16'd60, 16'd72, 16'd96, 16'd120, 16'd180, 16'd240},
  parameter int START_WAIT  = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [3:0]          stride,
  input  logic [3:0]          first_level,
  input  logic [3:0]          last_level,
  window_scheduler_if.master  win,
  output logic                busy,
  output logic                done,
  output logic [31:0]         window_count
);

  typedef logic [COORD_W:0] coord_ext_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam coord_ext_t  SPAN1     = coord_ext_t'(WINDOW_SIZE + 1);
  localparam logic [31:0] WAIT_LOAD = (START_WAIT > 0) ? 32'(START_WAIT - 1) : 32'd0;
  localparam logic [4:0]  LEVELS_EXT = 5'(NUM_LEVELS);

  // A level holds windows only if both axes span at least WINDOW_SIZE+1 points.
  function automatic logic level_nonempty(input logic [4:0] lvl);
    logic ok;
    ok = 1'b0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      ok = ok | ((5'(l) == lvl) &&
                 ({1'b0, LEVEL_WIDTHS[l]} >= SPAN1) &&
                 ({1'b0, LEVEL_HEIGHTS[l]} >= SPAN1));
    end
    return ok;
  endfunction

  function automatic coord_ext_t max_col(input logic [3:0] lvl);
    coord_ext_t m;
    m = {(COORD_W+1){1'b0}};
    for (int l = 0; l < NUM_LEVELS; l++) begin
      m = (4'(l) == lvl) ? ({1'b0, LEVEL_WIDTHS[l]} - SPAN1) : m;
    end
    return m;
  endfunction

  function automatic coord_ext_t max_row(input logic [3:0] lvl);
    coord_ext_t m;
    m = {(COORD_W+1){1'b0}};
    for (int l = 0; l < NUM_LEVELS; l++) begin
      m = (4'(l) == lvl) ? ({1'b0, LEVEL_HEIGHTS[l]} - SPAN1) : m;
    end
    return m;
  endfunction

  // Lowest non-empty level in [from_lvl, to_lvl]; result is {found, level}.
  function automatic logic [4:0] find_level(input logic [4:0] from_lvl, input logic [4:0] to_lvl);
    logic       found;
    logic       hit;
    logic [3:0] lvl;
    found = 1'b0;
    lvl   = 4'd0;
    for (int l = NUM_LEVELS - 1; l >= 0; l--) begin
      hit   = (5'(l) >= from_lvl) && (5'(l) <= to_lvl) && level_nonempty(5'(l));
      lvl   = hit ? 4'(l) : lvl;
      found = found | hit;
    end
    return {found, lvl};
  endfunction

  state_t             state_r;
  logic [31:0]        wait_cnt_r;
  logic [3:0]         stride_r;
  logic [3:0]         first_r;
  logic [3:0]         last_r;
  logic               win_valid_r;
  logic [3:0]         level_r;
  logic [COORD_W-1:0] row_r;
  logic [COORD_W-1:0] col_r;
  logic               lil_r;
  logic               last_flag_r;
  logic               busy_r;
  logic               done_r;
  logic [31:0]        window_count_r;

  coord_ext_t         stride_ext_s;
  coord_ext_t         col_step_s;
  coord_ext_t         row_step_s;
  coord_ext_t         nxt_row_s;
  coord_ext_t         nxt_col_s;
  logic [3:0]         nxt_level_s;
  logic               nxt_found_s;
  logic               nxt_lil_s;
  logic               nxt_last_s;
  logic [4:0]         search_s;
  logic [4:0]         later_s;
  logic               cfg_ok_s;
  logic               handshake_s;

  assign stride_ext_s = coord_ext_t'(stride_r);
  assign cfg_ok_s     = (first_r <= last_r) && ({1'b0, last_r} < LEVELS_EXT);
  assign handshake_s  = win_valid_r && win.win_ready;

  // Next window position (entry point when leaving WAIT, raster step otherwise) and its flags.
  always_comb begin
    nxt_level_s = level_r;
    nxt_row_s   = {1'b0, row_r};
    nxt_col_s   = {1'b0, col_r};
    nxt_found_s = 1'b0;
    search_s    = 5'd0;
    col_step_s  = {1'b0, col_r} + stride_ext_s;
    row_step_s  = {1'b0, row_r} + stride_ext_s;
    if (state_r == ST_WAIT) begin
      search_s    = find_level({1'b0, first_r}, {1'b0, last_r});
      nxt_found_s = search_s[4] && cfg_ok_s;
      nxt_level_s = search_s[3:0];
      nxt_row_s   = {(COORD_W+1){1'b0}};
      nxt_col_s   = {(COORD_W+1){1'b0}};
    end else if (col_step_s <= max_col(level_r)) begin
      nxt_col_s   = col_step_s;
      nxt_found_s = 1'b1;
    end else if (row_step_s <= max_row(level_r)) begin
      nxt_row_s   = row_step_s;
      nxt_col_s   = {(COORD_W+1){1'b0}};
      nxt_found_s = 1'b1;
    end else begin
      search_s    = find_level({1'b0, level_r} + 5'd1, {1'b0, last_r});
      nxt_found_s = search_s[4];
      nxt_level_s = search_s[3:0];
      nxt_row_s   = {(COORD_W+1){1'b0}};
      nxt_col_s   = {(COORD_W+1){1'b0}};
    end
    later_s    = find_level({1'b0, nxt_level_s} + 5'd1, {1'b0, last_r});
    nxt_lil_s  = ((nxt_col_s + stride_ext_s) > max_col(nxt_level_s)) &&
                 ((nxt_row_s + stride_ext_s) > max_row(nxt_level_s));
    nxt_last_s = nxt_lil_s && !later_s[4];
  end

  // Control FSM with registered window, status and counter outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      wait_cnt_r     <= 32'd0;
      stride_r       <= 4'd1;
      first_r        <= 4'd0;
      last_r         <= 4'(NUM_LEVELS - 1);
      win_valid_r    <= 1'b0;
      level_r        <= 4'd0;
      row_r          <= {COORD_W{1'b0}};
      col_r          <= {COORD_W{1'b0}};
      lil_r          <= 1'b0;
      last_flag_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      window_count_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            stride_r       <= (stride == 4'd0) ? 4'd1 : stride;
            first_r        <= first_level;
            last_r         <= last_level;
            window_count_r <= 32'd0;
            wait_cnt_r     <= WAIT_LOAD;
            busy_r         <= 1'b1;
            state_r        <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (wait_cnt_r != 32'd0) begin
            wait_cnt_r <= wait_cnt_r - 32'd1;
          end else if (nxt_found_s) begin
            win_valid_r <= 1'b1;
            level_r     <= nxt_level_s;
            row_r       <= nxt_row_s[COORD_W-1:0];
            col_r       <= nxt_col_s[COORD_W-1:0];
            lil_r       <= nxt_lil_s;
            last_flag_r <= nxt_last_s;
            state_r     <= ST_SCAN;
          end else begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (handshake_s) begin
            if (window_count_r != 32'hFFFF_FFFF) begin
              window_count_r <= window_count_r + 32'd1;
            end else begin
              window_count_r <= window_count_r;
            end
            if (last_flag_r || !nxt_found_s) begin
              win_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= ST_IDLE;
            end else begin
              level_r     <= nxt_level_s;
              row_r       <= nxt_row_s[COORD_W-1:0];
              col_r       <= nxt_col_s[COORD_W-1:0];
              lil_r       <= nxt_lil_s;
              last_flag_r <= nxt_last_s;
            end
          end else begin
            state_r <= ST_SCAN;
          end
        end
        default: begin
          win_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign win.win_valid         = win_valid_r;
  assign win.win_level         = level_r;
  assign win.win_row           = row_r;
  assign win.win_col           = col_r;
  assign win.win_last_in_level = lil_r;
  assign win.win_last          = last_flag_r;
  assign busy                  = busy_r;
  assign done                  = done_r;
  assign window_count          = window_count_r;

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: two instances (level 1 normal / level 1 too small) share
// stimulus; every presented window is checked against a list built from the scan rules.
module tb_window_scheduler;
  localparam int NL = 2;
  localparam int WS = 4;
  localparam int CW = 16;
  localparam int SW = 3;

  typedef struct packed {
    logic [3:0]  level;
    logic [15:0] row;
    logic [15:0] col;
    logic        lil;
    logic        last;
  } win_t;

  typedef struct {
    int stride;
    int fl;
    int ll;
    int rdy_rand;
    int exp_a;
    int exp_b;
  } vec_t;

  int WA[2] = '{8, 6};
  int HA[2] = '{7, 5};
  int WB[2] = '{8, 4};
  int HB[2] = '{7, 4};

  logic clk = 1'b0;
  logic reset_n, start, abort, win_ready;
  logic [3:0] stride, first_level, last_level;
  logic busy_a, done_a, busy_b, done_b;
  logic [31:0] wc_a, wc_b;

  window_scheduler_if #(.COORD_W(CW)) ifa ();
  window_scheduler_if #(.COORD_W(CW)) ifb ();
  assign ifa.win_ready = win_ready;
  assign ifb.win_ready = win_ready;

  window_scheduler #(
    .NUM_LEVELS(NL), .WINDOW_SIZE(WS), .COORD_W(CW),
    .LEVEL_WIDTHS({16'd6, 16'd8}), .LEVEL_HEIGHTS({16'd5, 16'd7}), .START_WAIT(SW)
  ) dut_a (
    .clock(clk), .reset_n(reset_n), .start(start), .abort(abort), .stride(stride),
    .first_level(first_level), .last_level(last_level), .win(ifa),
    .busy(busy_a), .done(done_a), .window_count(wc_a)
  );

  window_scheduler #(
    .NUM_LEVELS(NL), .WINDOW_SIZE(WS), .COORD_W(CW),
    .LEVEL_WIDTHS({16'd4, 16'd8}), .LEVEL_HEIGHTS({16'd4, 16'd7}), .START_WAIT(SW)
  ) dut_b (
    .clock(clk), .reset_n(reset_n), .start(start), .abort(abort), .stride(stride),
    .first_level(first_level), .last_level(last_level), .win(ifb),
    .busy(busy_b), .done(done_b), .window_count(wc_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  win_t exp_a[$];
  win_t exp_b[$];
  int   done_seen[2];
  int   hs[2];
  logic last_hs[2];
  logic prev_stall[2];
  win_t prev_win[2];
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Expected window list straight from the scan rules: nested loops per level.
  task automatic build_exp(input int s_in, input int fl, input int ll);
    win_t q[$];
    win_t t;
    int s, w, h;
    s = (s_in == 0) ? 1 : s_in;
    for (int d = 0; d < 2; d++) begin
      q.delete();
      if (fl <= ll && ll < NL) begin
        for (int lv = fl; lv <= ll; lv++) begin
          w = (d == 0) ? WA[lv] : WB[lv];
          h = (d == 0) ? HA[lv] : HB[lv];
          if (w > WS && h > WS) begin
            for (int r = 0; r <= h - WS - 1; r += s)
              for (int c = 0; c <= w - WS - 1; c += s)
                q.push_back({4'(lv), 16'(r), 16'(c), 2'b00});
          end
        end
      end
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        t.last = (i == q.size() - 1);
        if (t.last) t.lil = 1'b1;
        else t.lil = (q[i+1].level != t.level);
        q[i] = t;
      end
      if (d == 0) exp_a = q;
      else exp_b = q;
    end
  endtask

  task automatic mon_dut(input int d, input logic v, input logic rdy, input win_t got,
                         input logic dn, input logic bz);
    win_t e;
    string sfx;
    sfx = (d == 0) ? "_a" : "_b";
    if (dn) done_seen[d]++;
    if (last_hs[d]) chk({"done_after_last", sfx}, {dn, bz, v}, 3'b100);
    last_hs[d] = 1'b0;
    if (v && prev_stall[d]) chk({"stable_while_stalled", sfx}, 64'(got), 64'(prev_win[d]));
    if (v && rdy && !abort && reset_n) begin
      hs[d]++;
      if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
        chk({"unexpected_window", sfx}, 64'(got), 64'd0 - 64'd1);
      end else begin
        if (d == 0) e = exp_a.pop_front();
        else e = exp_b.pop_front();
        chk({"window", sfx}, 64'(got), 64'(e));
      end
      last_hs[d] = got.last;
    end
    prev_stall[d] = v && !rdy;
    prev_win[d]   = got;
  endtask

  // Sample both instances away from the active edge.
  always @(negedge clk) begin
    mon_dut(0, ifa.win_valid, win_ready,
            {ifa.win_level, ifa.win_row, ifa.win_col, ifa.win_last_in_level, ifa.win_last},
            done_a, busy_a);
    mon_dut(1, ifb.win_valid, win_ready,
            {ifb.win_level, ifb.win_row, ifb.win_col, ifb.win_last_in_level, ifb.win_last},
            done_b, busy_b);
  end

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      done_seen[d] = 0;
      hs[d] = 0;
    end
  endtask

  task automatic start_pulse(input int s, input int fl, input int ll);
    stride = 4'(s);
    first_level = 4'(fl);
    last_level = 4'(ll);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ifa.win_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(input int rdy_rand);
    int cyc;
    cyc = 0;
    while ((done_seen[0] == 0 || done_seen[1] == 0) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      win_ready = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (rdy_rand != 0) && busy_a && busy_b && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    win_ready = 1'b1;
    chk("done_within_budget", 64'(cyc < 500), 64'd1);
  endtask

  task automatic check_reset(input string sfx, input logic v, input logic bz, input logic dn,
                             input logic lil, input logic lst, input logic [3:0] lvl,
                             input logic [15:0] r, input logic [15:0] c, input logic [31:0] wc);
    chk({"reset_ctl", sfx}, {v, bz, dn, lil, lst, lvl}, 64'd0);
    chk({"reset_pos", sfx}, {r, c}, 64'd0);
    chk({"reset_cnt", sfx}, wc, 64'd0);
  endtask

  task automatic check_reset_both();
    check_reset("_a", ifa.win_valid, busy_a, done_a, ifa.win_last_in_level, ifa.win_last,
                ifa.win_level, ifa.win_row, ifa.win_col, wc_a);
    check_reset("_b", ifb.win_valid, busy_b, done_b, ifb.win_last_in_level, ifb.win_last,
                ifb.win_level, ifb.win_row, ifb.win_col, wc_b);
  endtask

  task automatic run_vec(input vec_t v);
    build_exp(v.stride, v.fl, v.ll);
    clear_stats();
    start_pulse(v.stride, v.fl, v.ll);
    wait_done(v.rdy_rand);
    repeat (2) @(posedge clk);
    #1;
    chk("count_a", wc_a, 64'(v.exp_a));
    chk("count_b", wc_b, 64'(v.exp_b));
    chk("drained", 64'(exp_a.size() + exp_b.size()), 64'd0);
    chk("done_pulses", {32'(done_seen[0]), 32'(done_seen[1])}, {32'd1, 32'd1});
    chk("idle_after_done", {busy_a, busy_b, ifa.win_valid, ifb.win_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    tbl[0]  = '{1, 0, 1, 0, 14, 12};
    tbl[1]  = '{2, 0, 1, 0, 5, 4};
    tbl[2]  = '{1, 0, 1, 1, 14, 12};
    tbl[3]  = '{0, 0, 1, 1, 14, 12};
    tbl[4]  = '{3, 0, 1, 1, 3, 2};
    tbl[5]  = '{1, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 2, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 0, 2, 0};
    tbl[8]  = '{1, 1, 1, 1, 2, 0};
    tbl[9]  = '{4, 0, 0, 1, 1, 1};
    tbl[10] = '{15, 0, 1, 0, 2, 1};
    for (int d = 0; d < 2; d++) begin
      last_hs[d] = 1'b0;
      prev_stall[d] = 1'b0;
      prev_win[d] = '0;
    end
    clear_stats();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; win_ready = 1'b1;
    stride = 4'd1; first_level = 4'd0; last_level = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_both();
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First window latency and the full 14 / 12 window scan.
    build_exp(1, 0, 1);
    clear_stats();
    start_pulse(1, 0, 1);
    wait_valid(lat);
    chk("first_valid_latency", 64'(lat), 64'd3);
    chk("busy_in_scan", {busy_a, busy_b}, 64'd3);
    wait_done(0);
    chk("count_full_a", wc_a, 64'd14);
    chk("count_full_b", wc_b, 64'd12);

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Abort after the 5th handshake; abort also beats a simultaneous handshake.
    build_exp(1, 0, 1);
    clear_stats();
    start_pulse(1, 0, 1);
    wait_valid(lat);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {ifa.win_valid, busy_a, ifb.win_valid, busy_b}, 64'd0);
    chk("abort_count_a", wc_a, 64'd5);
    chk("abort_hs_model", 64'(hs[0]), 64'(wc_a));
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_seen[0] + done_seen[1]), 64'd0);
    run_vec(tbl[0]);

    // Abort wins over start in IDLE.
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_beats_start", {busy_a, busy_b}, 64'd0);

    // Reset in the middle of a scan.
    build_exp(1, 0, 1);
    clear_stats();
    start_pulse(1, 0, 1);
    wait_valid(lat);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_both();
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(done_seen[0] + done_seen[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end
endmodule
